// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and helpers for the per-channel buffers behind demux1x2.
// Optional build macro consumed by vc_fifo: FIFO_DROP_CNT_EN.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 10;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_AF_LEVEL   = 6;
    localparam int unsigned DEF_AE_LEVEL   = 1;
    localparam int unsigned DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int unsigned cnt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned NUM_ENTRIES = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vc_fifo.sv
// Per-channel circular FIFO with registered pop data, watermarks and sticky error.
// Define FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module vc_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
`ifdef FIFO_DROP_CNT_EN
    output logic [7:0]            drop_cnt,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en, rd_en, drop, underflow;

    // Flags decode only the registered count, never the live requests.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    // A pop while full frees a slot in the same edge, so the push is taken too.
    assign wr_en     = push && (!full || pop);
    assign rd_en     = pop && !empty;
    assign drop      = push && full && !pop;
    assign underflow = pop && empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            count_q   <= count_d;
            valid_out <= rd_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= rd_data;
            end
            if (drop || underflow) begin
                error <= 1'b1;
            end
        end
    end

`ifdef FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: directed plan steps plus random traffic against a queue model.
module tb_vc_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [9:0] data_in = '0;
    logic [9:0] data_out;
    logic       valid_out, full, empty, almost_full, almost_empty, error;
    logic [3:0] count;
`ifdef FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue plus the observable registered outputs.
    logic [9:0] q[$];
    logic [9:0] m_dout = '0;
    logic       m_valid = 1'b0;
    logic       m_err = 1'b0;
    int         m_drop = 0;

    vc_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
`ifdef FIFO_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
        chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
        chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
`ifdef FIFO_DROP_CNT_EN
        chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_drop  = 0;
    endtask

    // Called at posedge+1; drives one request set across the next edge, then checks.
    task automatic cycle(input string tag, input logic p, input logic [9:0] d, input logic r);
        int  n;
        logic take_w, take_r;
        push    = p;
        data_in = d;
        pop     = r;
        n       = q.size();
        take_r  = r && (n > 0);
        take_w  = p && ((n < 8) || r);
        if (take_r) begin
            m_dout = q.pop_front();
        end
        m_valid = take_r;
        if (take_w) begin
            q.push_back(d);
        end
        if ((p && n == 8 && !r) || (r && n == 0)) begin
            m_err = 1'b1;
        end
        if (p && n == 8 && !r && m_drop < 255) begin
            m_drop++;
        end
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [9:0] v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        // 1: two pushes, two pops
        cycle("t1.push0", 1'b1, 10'h0FF, 1'b0);
        cycle("t1.push1", 1'b1, 10'h0DD, 1'b0);
        cycle("t1.pop0", 1'b0, 10'h000, 1'b1);
        chk("t1.first_flit", 32'(data_out), 32'h0FF);
        cycle("t1.pop1", 1'b0, 10'h000, 1'b1);
        chk("t1.second_flit", 32'(data_out), 32'h0DD);
        chk("t1.no_error", 32'(error), 32'h0);

        // 2: fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            cycle("t2.fill", 1'b1, 10'(10'h080 + i), 1'b0);
        end
        chk("t2.full", 32'(full), 32'h1);
        cycle("t2.overflow", 1'b1, 10'h0AA, 1'b0);
        chk("t2.count_held", 32'(count), 32'h8);
        chk("t2.error_set", 32'(error), 32'h1);

        // 3: push+pop while full, then drain
        cycle("t3.pushpop_full", 1'b1, 10'h0BB, 1'b1);
        chk("t3.head_flit", 32'(data_out), 32'h080);
        for (int i = 0; i < 8; i++) begin
            cycle("t3.drain", 1'b0, 10'h000, 1'b1);
        end
        chk("t3.last_flit", 32'(data_out), 32'h0BB);

        // 4: wrap-around with low occupancy
        for (int i = 0; i < 12; i++) begin
            v = 10'($urandom);
            cycle("t4.push", 1'b1, v, 1'b0);
            cycle("t4.pop", 1'b0, 10'h000, 1'b1);
            chk("t4.roundtrip", 32'(data_out), 32'(v));
        end

        // 5: pop while empty, then push+pop while empty
        cycle("t5.pop_empty", 1'b0, 10'h000, 1'b1);
        cycle("t5.pushpop_empty", 1'b1, 10'h3C3, 1'b1);
        chk("t5.count_one", 32'(count), 32'h1);

        // 6: asynchronous reset with 4 flits stored
        for (int i = 0; i < 3; i++) begin
            cycle("t6.fill", 1'b1, 10'($urandom), 1'b0);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6.async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle("t6.pop_after_reset", 1'b0, 10'h000, 1'b1);

        // Random traffic: balanced, then push-heavy, then pop-heavy
        for (int i = 0; i < 300; i++) begin
            cycle("rand.bal", 1'($urandom_range(0, 99) < 55), 10'($urandom),
                  1'($urandom_range(0, 99) < 50));
        end
        for (int i = 0; i < 150; i++) begin
            cycle("rand.push", 1'($urandom_range(0, 99) < 85), 10'($urandom),
                  1'($urandom_range(0, 99) < 25));
        end
        for (int i = 0; i < 150; i++) begin
            cycle("rand.pop", 1'($urandom_range(0, 99) < 25), 10'($urandom),
                  1'($urandom_range(0, 99) < 85));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Per-channel buffer directly downstream of the 1x2 demultiplexer. One instance sits on each demux output, so push/data come from the push_N/outN pair. It stores 10-bit flits in a circular register array and presents them to the downstream arbiter through a pop interface with registered read data. It exports full/empty and programmable almost-full/almost-empty watermarks for upstream flow control.

Parameters:
DATA_WIDTH, 10, flit width; matches the demux data path.
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries.
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  in  1  single clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
push  in  1  write request from demux, qualified every cycle.
data_in  in  DATA_WIDTH  flit written when push is accepted.
pop  in  1  read request from downstream.
data_out  out  DATA_WIDTH  registered read data.
valid_out  out  1  data_out holds a flit popped in the previous cycle.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
error  out  1  sticky overflow/underflow flag.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0. Therefore empty=1, almost_empty=1, full=0, almost_full=0. Array contents are not cleared. Reset asserted mid-operation discards all stored flits immediately.
- Write: push && !full -> mem[wr_ptr]<=data_in; wr_ptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Read: pop && !empty -> data_out<=mem[rd_ptr]; valid_out<=1; rd_ptr increments modulo DEPTH. Latency is 1 cycle from the pop edge to data on data_out.
- Otherwise valid_out<=0 and data_out holds its last value.
- Count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- Push+pop while full: both are accepted; count stays DEPTH; no error.
- Push+pop while empty: push is accepted, pop is ignored (no bypass); count becomes 1; error is set (underflow).
- Push while full without pop: data is dropped; pointers and count are unchanged; error is set (overflow).
- Pop while empty: ignored; valid_out=0; error is set.
- error stays set until reset.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free relative to clk and never depend on push or pop in the same cycle.
- Undefined push or pop (X) is not supported; the bench drives both to 0 during reset.

Optional Feature:
FIFO_DROP_CNT_EN:
- Defined: adds output drop_cnt[7:0]. It increments on each dropped push (full, no simultaneous pop) and saturates at 8'hFF. Reset clears it to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH default (10), shared with demux1x2.
  - Default ADDR_WIDTH, AF_LEVEL and AE_LEVEL.
  - Localparam DEPTH and the count width function.
- One natural sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read at rd_ptr.
  - It has no reset of contents.
  - vc_fifo owns the pointers, count, flags and the data_out register.

Test Plan:
1. Reset, then push 10'h0FF and 10'h0DD on consecutive cycles, then pop twice -> count 1,2,1,0. data_out = 10'h0FF with valid_out=1 one cycle after the first pop, then 10'h0DD. empty returns to 1 and error=0.
2. Push 8 flits 10'h080..10'h087 -> almost_full rises when count reaches 6, full=1 at count 8. A ninth push of 10'h0AA is dropped, error=1, count stays 8. With FIFO_DROP_CNT_EN, drop_cnt=1.
3. While full, assert push 10'h0BB and pop together for 1 cycle -> data_out=10'h080, count stays 8, error unchanged. Draining all 8 then yields 10'h081..10'h087 followed by 10'h0BB.
4. Wrap-around: do 12 push/pop pairs spaced so count <= 2 -> pointers wrap past 7. Every popped value equals the pushed value in order. almost_empty=1 throughout.
5. Pop while empty, then push+pop while empty -> valid_out=0 both cycles, error=1, count=1 after the second cycle.
6. With 4 flits stored, assert reset low between clock edges -> count=0, empty=1, valid_out=0 and error=0 immediately, without waiting for clk. After release, the first pop is ignored.
